// File: rtl/kplic_gateway_if.sv
// rtl/kplic_gateway_if.sv - interrupt gateway signal bundle between raw lines, registers and core
interface kplic_gateway_if #(
    parameter int INT_NUM   = 32,
    parameter int INT_WIDTH = 5
);
    logic [INT_NUM-1:0]   ext_int_src;
    logic [INT_NUM-1:0]   int_enable;
    logic [INT_NUM-1:0]   int_trig_edge;
    logic                 int_complete;
    logic [INT_WIDTH-1:0] complete_id;
    logic [INT_NUM-1:0]   valid_int_req;
    logic [INT_NUM-1:0]   gw_inflight;

    modport master (
        output ext_int_src,
        output int_enable,
        output int_trig_edge,
        output int_complete,
        output complete_id,
        input  valid_int_req,
        input  gw_inflight
    );

    modport slave (
        input  ext_int_src,
        input  int_enable,
        input  int_trig_edge,
        input  int_complete,
        input  complete_id,
        output valid_int_req,
        output gw_inflight
    );
endinterface

// File: rtl/kplic_gateway.sv
// rtl/kplic_gateway.sv - per-source interrupt gateway with sync, level/edge trigger and completion blocking
module kplic_gateway #(
    parameter int INT_NUM    = 32,
    parameter int INT_WIDTH  = 5,
    parameter int EDGE_CNT_W = 3
) (
    input  logic            kplic_clk,
    input  logic            kplic_rstn,
    kplic_gateway_if.slave  gw
);

    typedef enum logic [1:0] {
        GW_IDLE = 2'd0,
        GW_REQ  = 2'd1,
        GW_WAIT = 2'd2
    } gw_state_t;

    localparam logic [EDGE_CNT_W-1:0] CNT_MAX = '1;

    logic [INT_NUM-1:0]    sync_s1;
    logic [INT_NUM-1:0]    sync_s2;
    logic [INT_NUM-1:0]    sync_s3;
    logic [INT_NUM-1:0]    rise;
    logic [INT_NUM-1:0]    take;
    logic [INT_NUM-1:0]    req_d;
    logic [INT_NUM-1:0]    infl_d;
    logic [INT_NUM-1:0]    valid_q;
    logic [INT_NUM-1:0]    infl_q;
    gw_state_t             state_q [INT_NUM];
    gw_state_t             state_d [INT_NUM];
    logic [EDGE_CNT_W-1:0] cnt_q   [INT_NUM];
    logic [EDGE_CNT_W-1:0] cnt_d   [INT_NUM];

    // Two-flop synchroniser plus one history flop for rising-edge detection.
    always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
        if (!kplic_rstn) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
            sync_s3 <= '0;
        end else begin
            sync_s1 <= gw.ext_int_src;
            sync_s2 <= sync_s1;
            sync_s3 <= sync_s2;
        end
    end

    // Per-source next state, pending-edge counter and registered output values.
    always_comb begin
        rise   = sync_s2 & ~sync_s3;
        take   = '0;
        req_d  = '0;
        infl_d = '0;
        for (int i = 0; i < INT_NUM; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];

            // Source 0 is reserved: it can never leave IDLE.
            take[i] = (i != 0) && (state_q[i] == GW_IDLE) && gw.int_enable[i] &&
                      (gw.int_trig_edge[i] ? ((cnt_q[i] != '0) || rise[i]) : sync_s2[i]);

            case (state_q[i])
                GW_IDLE: if (take[i]) state_d[i] = GW_REQ;
                GW_REQ:  state_d[i] = GW_WAIT;
                GW_WAIT: if (gw.int_complete && (gw.complete_id == INT_WIDTH'(i)))
                             state_d[i] = GW_IDLE;
                default: state_d[i] = GW_IDLE;
            endcase

            // A queued edge is consumed before a fresh one; a fresh edge that
            // triggers the request directly is never counted.
            if ((i == 0) || !gw.int_enable[i] || !gw.int_trig_edge[i]) begin
                cnt_d[i] = '0;
            end else if (take[i] && (cnt_q[i] != '0)) begin
                if (!rise[i]) begin
                    cnt_d[i] = cnt_q[i] - EDGE_CNT_W'(1);
                end
            end else if (rise[i] && !take[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + EDGE_CNT_W'(1);
            end

            req_d[i]  = (state_d[i] == GW_REQ);
            infl_d[i] = (state_d[i] == GW_REQ) || (state_d[i] == GW_WAIT);
        end
    end

    // State and counter registers for every source.
    always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
        if (!kplic_rstn) begin
            for (int i = 0; i < INT_NUM; i++) begin
                state_q[i] <= GW_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < INT_NUM; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Output flops so the core and register block see glitch-free status.
    always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
        if (!kplic_rstn) begin
            valid_q <= '0;
            infl_q  <= '0;
        end else begin
            valid_q <= req_d;
            infl_q  <= infl_d;
        end
    end

    assign gw.valid_int_req = valid_q;
    assign gw.gw_inflight   = infl_q;

endmodule

// File: doc/kplic_gateway.md
Name: kplic_gateway

Overview:
- Per-source interrupt gateway directly upstream of the KPLIC core.
- Synchronises raw external interrupt lines and applies per-source enable and trigger type (level/edge).
- Forwards at most one request per source to the core as a single-cycle `valid_int_req` pulse.
- Blocks further requests from that source until the target signals completion; edges arriving meanwhile are queued in a saturating counter.

Parameters:
- INT_NUM, 32: number of interrupt sources; source 0 is reserved (never requests).
- INT_WIDTH, 5: width of a source ID, equal to log2(INT_NUM).
- EDGE_CNT_W, 3: width of the per-source pending-edge counter; saturates at 2^EDGE_CNT_W-1 (7).

Ports:
- kplic_clk  in  1  KPLIC clock
- kplic_rstn  in  1  KPLIC reset, asynchronous, active-low
- ext_int_src  in  INT_NUM  raw asynchronous interrupt lines, active-high
- int_enable  in  INT_NUM  per-source enable (from kplic_reg)
- int_trig_edge  in  INT_NUM  per-source trigger type: 1 = rising-edge, 0 = level-high (from kplic_reg)
- int_complete  in  1  completion strobe from target, one cycle
- complete_id  in  INT_WIDTH  ID of the source being completed, valid with int_complete
- valid_int_req  out  INT_NUM  one-cycle request pulse per source, to kplic_core
- gw_inflight  out  INT_NUM  source has forwarded a request not yet completed (status to kplic_reg)

Behaviour:
- Reset: kplic_rstn is asynchronous, active-low; clock is kplic_clk.
  - All synchroniser flops, edge-history flops and edge counters clear to 0.
  - All per-source FSMs go to IDLE.
  - valid_int_req = 0 and gw_inflight = 0.
  - Reset mid-operation drops all in-flight and queued requests.
- Sync:
  - ext_int_src[i] passes through 2 flops (s1 -> s2).
  - s3 holds the previous s2.
  - rise[i] = s2 & ~s3.
- Per-source FSM, for i = 1..INT_NUM-1. Source 0: FSM held in IDLE, valid_int_req[0] = 0, gw_inflight[0] = 0.
  - IDLE -> REQ when int_enable[i] and any of:
    - level mode and s2 = 1;
    - edge mode and (cnt > 0 or rise[i]).
  - REQ -> WAIT unconditionally after one cycle.
  - WAIT -> IDLE when int_complete and complete_id == i.
  - WAIT ignores completions with a different ID.
  - A completion for a source in IDLE or REQ is ignored. It is not remembered.
- Outputs (all registered):
  - valid_int_req[i] = (state == REQ).
  - gw_inflight[i] = (state == REQ or state == WAIT).
- Latency: source asserted (setup met) before clock edge E0 -> valid_int_req[i] high exactly for the cycle after E2. The same holds for level and edge mode.
- Re-arm: complete at edge Ec -> state IDLE after Ec. If the source is still requesting, REQ is entered after Ec+1, i.e. a minimum 1 IDLE cycle between pulses.
- Edge counter (edge mode only):
  - Increments on rise[i] while enabled, in any state, except when that same rise is consumed by the IDLE -> REQ transition.
  - Decrements when IDLE -> REQ is taken with cnt > 0; the queued edge is consumed first.
  - Simultaneous rise and decrement leave the counter unchanged.
  - Saturates at max; excess edges are dropped.
  - Cleared when int_enable[i] = 0 or int_trig_edge[i] = 0.
- Level mode: no queuing. The line is re-evaluated on return to IDLE. A line that deasserts while in WAIT generates no further request.
- Disable:
  - int_enable[i] falling while in REQ or WAIT does not abort; the FSM waits for completion as normal.
  - While disabled, IDLE never leaves and rise edges are discarded.
- Trigger-type change takes effect on the next IDLE evaluation.
- Multiple sources may pulse valid_int_req in the same cycle. Sources are fully independent.

Test Plan:
1. Level, src 5, enable=1, edge=0: hold ext_int_src[5] high from E0 -> valid_int_req[5] pulses 1 cycle after E2; gw_inflight[5] = 1. Complete id 5 at E10 -> second pulse after E11.
2. Edge, src 3: 4 rising edges spaced 4 cycles apart before any completion -> 1 pulse, then cnt = 3. Three completions of id 3 -> exactly 3 more pulses, then cnt = 0 and no further pulses.
3. Edge saturation, src 7: 10 edges while in WAIT -> cnt = 7. Complete repeatedly -> exactly 7 more pulses.
4. Mismatched completion: src 2 in WAIT, complete_id = 4 -> src 2 remains in WAIT, gw_inflight[2] = 1. Completion of id 4 while src 4 is IDLE -> no effect.
5. Disable mid-flight: src 9 in WAIT, int_enable[9] -> 0 with cnt = 2 -> cnt cleared. After complete id 9 -> IDLE with no pulse, even while the line is high.
6. Source 0 driven high in both modes, and reset asserted mid-WAIT on src 6 -> valid_int_req[0] never set. All outputs 0 immediately on reset assertion, with no pulse after release unless the source line requests anew.
